fifo_rd_stream: RTL



---
 rtl/fifo_rd_stream_if.sv | 12 +
 rtl/fifo_rd_stream.sv | 69 ++++++
 2 files changed

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying words popped from the read side of the dual-clock FIFO.
interface fifo_rd_stream_if #(
  parameter int unsigned DATA_W = 8
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side FIFO drain: issues pops, captures the registered FIFO output into a
// 2-entry skid buffer and presents it as a packetised valid/ready stream.
module fifo_rd_stream #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PKT_LEN = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk_r,
  input  logic              rst_n,
  input  logic              en,
  input  logic              fifo_empty,
  output logic              fifo_r_en,
  input  logic [DATA_W-1:0] fifo_data,
  fifo_rd_stream_if.master  m,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              busy
);

  localparam logic [7:0]       PKT_LAST = 8'(PKT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DATA_W-1:0] skid [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic              inflight;
  logic [1:0]        occ;
  logic [7:0]        pkt_cnt;
  logic              take;
  logic [1:0]        committed;

  always_comb begin
    m.m_valid = (occ != '0);
    m.m_data  = skid[rd_ptr];
    m.m_last  = m.m_valid && (pkt_cnt == PKT_LAST);
    take      = m.m_valid && m.m_ready;
    // Slots already spoken for once this cycle's take retires; never exceeds 2.
    committed = occ + {1'b0, inflight} - {1'b0, take};
    // rst_n gate keeps the pop request low for the whole reset window.
    fifo_r_en = rst_n && en && !fifo_empty && (committed < 2'd2);
    busy      = (occ != '0) || inflight;
  end

  always_ff @(posedge clk_r or negedge rst_n) begin
    if (!rst_n) begin
      skid[0]  <= '0;
      skid[1]  <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      inflight <= 1'b0;
      occ      <= '0;
      pkt_cnt  <= '0;
      word_cnt <= '0;
    end else begin
      inflight <= fifo_r_en;
      // FIFO output holds the word popped on the previous edge.
      if (inflight) begin
        skid[wr_ptr] <= fifo_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (take) begin
        rd_ptr   <= ~rd_ptr;
        pkt_cnt  <= (pkt_cnt == PKT_LAST) ? '0 : pkt_cnt + 8'd1;
        word_cnt <= word_cnt + CNT_ONE;
      end
      occ <= occ + {1'b0, inflight} - {1'b0, take};
    end
  end

endmodule
